wait_state_ram: RTL and testbench
=================================

WAIT_STATE_RAM -- requirements
Module: wait_state_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte address width; storage is 2^(ADDR_WIDTH-1) words indexed by addr[ADDR_WIDTH-1:1].
REQ-002 Parameter DATA_WIDTH, default 16, word width.
REQ-003 Parameter WAIT_STATES, default 2, range 0..15, extra cycles inserted before each access completes.
REQ-004 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port addr, input, ADDR_WIDTH, byte address from the initiator.
REQ-007 Port data, inout, DATA_WIDTH, shared bus; initiator drives it for writes, this block drives it only for reads.
REQ-008 Port chip_select_in, input, 1, request qualifier.
REQ-009 Port write_enable, input, 1, write request.
REQ-010 Port output_enable, input, 1, read request / bus-turnaround grant.
REQ-011 Port ready, output, 1, one-cycle access-complete pulse.
REQ-012 Port err, output, 1, one-cycle rejected-access pulse (see Configuration).

Function
REQ-013 States: IDLE, WAIT, DONE, HOLD.
REQ-014 In IDLE, a write is accepted at a rising edge when chip_select_in=1, write_enable=1, output_enable=0; addr and data are latched at that edge.
REQ-015 In IDLE, a read is accepted at a rising edge when chip_select_in=1, write_enable=0, output_enable=1; addr is latched at that edge.
REQ-016 In IDLE, chip_select_in=1 with write_enable=output_enable (both 0 or both 1) is ignored; state stays IDLE, no pulse.
REQ-017 Acceptance at edge T: state goes to WAIT with counter loaded to WAIT_STATES-1 if WAIT_STATES>0, else directly to DONE.
REQ-018 WAIT decrements the counter each edge; transitions to DONE at the edge where the counter is 0, so DONE begins at edge T+WAIT_STATES+1.
REQ-019 DONE lasts exactly one cycle; ready=1 only in DONE.
REQ-020 Write commit: latched data written to the latched word at the edge entering DONE; a read of the same word accepted later returns the new value.
REQ-021 Read: memory word loaded into an output register at the edge entering DONE; data driven from that register in DONE and HOLD; high-Z in all other states.
REQ-022 DONE always goes to HOLD.
REQ-023 HOLD exits to IDLE at the first edge where chip_select_in=0, or addr differs from the latched addr, or {write_enable,output_enable} differ from the latched operation; the new request is not accepted on that same edge (evaluated from IDLE next edge).
REQ-024 chip_select_in=0 sampled in WAIT aborts the access: return to IDLE, no write commit, no ready.
REQ-025 Changes to addr/data/enables during WAIT are ignored (latched values used).
REQ-026 addr[0] is ignored for indexing; address wraps naturally within ADDR_WIDTH.

Reset
REQ-027 rst_n=0 forces, asynchronously: state IDLE, counter 0, ready=0, err=0, data high-Z, output register 0.
REQ-028 Reset during WAIT drops the pending write; array contents are never reset or altered by reset.
REQ-029 First access accepted no earlier than the first rising edge after rst_n returns high.

Configuration
REQ-030 Macro WSRAM_MISALIGN_CHECK_EN: when defined, an otherwise-valid request in IDLE with addr[0]=1 is rejected: err=1 for the next cycle, no state change, no write, no ready, bus stays high-Z.
REQ-031 Without WSRAM_MISALIGN_CHECK_EN: err is tied 0 and addr[0]=1 accesses proceed as addr[0]=0.

Verification
REQ-032 WAIT_STATES=2; write 'h111C to 'h100 accepted at edge T -> ready high in cycle starting T+3, no bus drive by block.
REQ-033 Read 'h100 after REQ-032 write, holding enables -> data='h111C from ready cycle until addr changes to 'h102, then high-Z next edge.
REQ-034 WAIT_STATES=0; back-to-back reads 'h102 then 'h104 with chip_select_in held 1 -> each ready 1 cycle after acceptance, one IDLE cycle between.
REQ-035 Write 'hFFFF to 'h122, drop chip_select_in during WAIT -> no ready; subsequent read 'h122 returns prior contents.
REQ-036 rst_n pulsed low mid-WAIT of write 'h0001 to 'h11E -> immediate IDLE, ready=0, data high-Z; read 'h11E returns prior value.
REQ-037 With WSRAM_MISALIGN_CHECK_EN, read at 'h101 -> err=1 one cycle, no ready; without macro -> returns word at 'h100.

Source files
------------

// File: rtl/wait_state_ram.sv
// Word-wide RAM on a shared tristate bus that inserts WAIT_STATES extra cycles before each access completes.
// Optional misaligned-access rejection when the WSRAM_MISALIGN_CHECK_EN macro is defined.
module wait_state_ram #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  chip_select_in,
  input  logic                  write_enable,
  input  logic                  output_enable,
  output logic                  ready,
  output logic                  err
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic                    lat_we;
  logic                    lat_oe;
  logic [DATA_WIDTH-1:0]   rd_reg;
  logic                    drive;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req_valid;
  logic                    reject;
  logic                    commit;
  logic [ADDR_WIDTH-2:0]   idx;

  assign req_valid = chip_select_in && (write_enable != output_enable);
  assign idx       = lat_addr[ADDR_WIDTH-1:1];
  assign commit    = (state == WAIT) && chip_select_in && (cnt == 4'd0);

`ifdef WSRAM_MISALIGN_CHECK_EN
  logic err_q;
  assign reject = addr[0];
  assign err    = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  assign data = drive ? rd_reg : {DATA_WIDTH{1'bz}};

  // Array has no reset; reset forces state to IDLE so commit cannot fire.
  always_ff @(posedge clk) begin
    if (commit && lat_we)
      mem[idx] <= lat_data;
  end

  // WAIT spans WAIT_STATES+1 cycles, so DONE begins WAIT_STATES+1 edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      drive    <= 1'b0;
      rd_reg   <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      lat_oe   <= 1'b0;
`ifdef WSRAM_MISALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ready <= 1'b0;
`ifdef WSRAM_MISALIGN_CHECK_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (reject) begin
`ifdef WSRAM_MISALIGN_CHECK_EN
              err_q <= 1'b1;
`endif
            end else begin
              lat_addr <= addr;
              lat_data <= data;
              lat_we   <= write_enable;
              lat_oe   <= output_enable;
              cnt      <= 4'(WAIT_STATES);
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!chip_select_in) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            ready <= 1'b1;
            state <= DONE;
            if (lat_oe) begin
              rd_reg <= mem[idx];
              drive  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: state <= HOLD;
        HOLD: begin
          if (!chip_select_in || (addr != lat_addr) ||
              (write_enable != lat_we) || (output_enable != lat_oe)) begin
            drive <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench for wait_state_ram: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
module tb_wait_state_ram;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr_s [2];
  logic        cs     [2];
  logic        we     [2];
  logic        oe     [2];
  logic        rdy    [2];
  logic        er     [2];
  logic [15:0] tdrv   [2];
  logic        ten    [2];
  wire  [15:0] bus_a;
  wire  [15:0] bus_b;

  int checks = 0;
  int errors = 0;

  assign bus_a = ten[0] ? tdrv[0] : 16'hzzzz;
  assign bus_b = ten[1] ? tdrv[1] : 16'hzzzz;

  wait_state_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst_n(rst_n), .addr(addr_s[0]), .data(bus_a),
    .chip_select_in(cs[0]), .write_enable(we[0]), .output_enable(oe[0]),
    .ready(rdy[0]), .err(er[0]));

  wait_state_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .addr(addr_s[1]), .data(bus_b),
    .chip_select_in(cs[1]), .write_enable(we[1]), .output_enable(oe[1]),
    .ready(rdy[1]), .err(er[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] bus(input int u);
    return (u == 0) ? bus_a : bus_b;
  endfunction

  // Drive zero onto the bus briefly; any DUT drive would corrupt the value.
  task automatic bus_free(input int u, input string tag);
    ten[u]  = 1'b1;
    tdrv[u] = 16'h0000;
    #1;
    check(tag, bus(u), 16'h0000);
    ten[u]  = 1'b0;
  endtask

  task automatic setreq(input int u, input logic c, input logic w, input logic o,
                        input logic [11:0] a, input logic [15:0] d);
    cs[u]     = c;
    we[u]     = w;
    oe[u]     = o;
    addr_s[u] = a;
    tdrv[u]   = d;
    ten[u]    = c & w & ~o;
  endtask

  task automatic release_bus(input int u);
    setreq(u, 1'b0, 1'b0, 1'b0, addr_s[u], 16'h0000);
    tick();
    tick();
  endtask

  // Ends sampling the DONE cycle; ready must appear exactly ws+2 samples after the request is set up.
  task automatic run_access(input int u, input int ws, input logic w,
                            input logic [11:0] a, input logic [15:0] d, input string tag);
    setreq(u, 1'b1, w, ~w, a, d);
    for (int k = 1; k <= ws + 2; k++) begin
      tick();
      check($sformatf("%s_rdy%0d", tag, k), rdy[u], (k == ws + 2));
    end
  endtask

  task automatic read_word(input int u, input int ws, input logic [11:0] a,
                           input logic [15:0] exp, input string tag);
    run_access(u, ws, 1'b0, a, 16'h0000, tag);
    check({tag, "_dat"}, bus(u), exp);
    release_bus(u);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) setreq(u, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_rdy0", rdy[0], 1'b0);
    check("rst_err0", er[0], 1'b0);
    check("rst_rdy1", rdy[1], 1'b0);
    bus_free(0, "rst_bus0");
    bus_free(1, "rst_bus1");
    rst_n = 1'b1;
    tick();

    // Write 111C to 100 with two wait states; bus carries only the initiator's value.
    run_access(0, 2, 1'b1, 12'h100, 16'h111C, "wr100");
    check("wr100_bus", bus_a, 16'h111C);
    tick();
    check("wr100_hold_rdy", rdy[0], 1'b0);
    release_bus(0);

    // Read back holding enables, then move the address to release the bus.
    run_access(0, 2, 1'b0, 12'h100, 16'h0000, "rd100");
    check("rd100_done_dat", bus_a, 16'h111C);
    tick();
    check("rd100_hold_dat", bus_a, 16'h111C);
    check("rd100_hold_rdy", rdy[0], 1'b0);
    addr_s[0] = 12'h102;
    tick();
    bus_free(0, "rd100_exit_bus");
    release_bus(0);

    // Abort a write by dropping chip select mid-wait.
    run_access(0, 2, 1'b1, 12'h122, 16'h5A5A, "wr122");
    release_bus(0);
    setreq(0, 1'b1, 1'b1, 1'b0, 12'h122, 16'hFFFF);
    tick();
    tick();
    setreq(0, 1'b0, 1'b0, 1'b0, 12'h122, 16'h0000);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("abort_rdy%0d", k), rdy[0], 1'b0);
    end
    read_word(0, 2, 12'h122, 16'h5A5A, "rd122");

    // Reset pulse during a pending write.
    run_access(0, 2, 1'b1, 12'h11E, 16'h0F0F, "wr11E");
    release_bus(0);
    setreq(0, 1'b1, 1'b1, 1'b0, 12'h11E, 16'h0001);
    tick();
    tick();
    rst_n = 1'b0;
    setreq(0, 1'b0, 1'b0, 1'b0, 12'h11E, 16'h0000);
    #1;
    check("rstmid_rdy", rdy[0], 1'b0);
    bus_free(0, "rstmid_bus");
    rst_n = 1'b1;
    tick();
    read_word(0, 2, 12'h11E, 16'h0F0F, "rd11E");

    // Requests with both or neither enable are ignored.
    setreq(0, 1'b1, 1'b1, 1'b1, 12'h100, 16'h0000);
    ten[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("both_rdy%0d", k), rdy[0], 1'b0);
    end
    setreq(0, 1'b1, 1'b0, 1'b0, 12'h100, 16'h0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("none_rdy%0d", k), rdy[0], 1'b0);
    end
    bus_free(0, "none_bus");
    release_bus(0);

`ifdef WSRAM_MISALIGN_CHECK_EN
    setreq(0, 1'b1, 1'b0, 1'b1, 12'h101, 16'h0000);
    tick();
    check("mis_err", er[0], 1'b1);
    check("mis_rdy", rdy[0], 1'b0);
    setreq(0, 1'b0, 1'b0, 1'b0, 12'h101, 16'h0000);
    tick();
    check("mis_err_clr", er[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mis_rdy%0d", k), rdy[0], 1'b0);
    end
    bus_free(0, "mis_bus");
`else
    read_word(0, 2, 12'h101, 16'h111C, "rd101");
    check("rd101_err", er[0], 1'b0);
`endif

    // Zero wait states: back-to-back reads with chip select held.
    run_access(1, 0, 1'b1, 12'h102, 16'hAAAA, "ws0_wr102");
    release_bus(1);
    run_access(1, 0, 1'b1, 12'h104, 16'hBBBB, "ws0_wr104");
    release_bus(1);
    setreq(1, 1'b1, 1'b0, 1'b1, 12'h102, 16'h0000);
    tick();
    check("b2b_acc1_rdy", rdy[1], 1'b0);
    tick();
    check("b2b_done1_rdy", rdy[1], 1'b1);
    check("b2b_done1_dat", bus_b, 16'hAAAA);
    tick();
    check("b2b_hold_rdy", rdy[1], 1'b0);
    addr_s[1] = 12'h104;
    tick();
    check("b2b_idle_rdy", rdy[1], 1'b0);
    bus_free(1, "b2b_idle_bus");
    tick();
    check("b2b_acc2_rdy", rdy[1], 1'b0);
    tick();
    check("b2b_done2_rdy", rdy[1], 1'b1);
    check("b2b_done2_dat", bus_b, 16'hBBBB);
    release_bus(1);
    bus_free(1, "b2b_end_bus");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
